// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage pipeline.
// Load-use / branch-in-ID stalls, control flushes, dmem freeze and watchdog.
module pipeline_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 255,
  parameter int WAIT_W   = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             MemRead_EX,
  input  logic [4:0]       Rt_EX,
  input  logic             RegWrite_EX,
  input  logic [4:0]       WriteReg_EX,
  input  logic             MemRead_MEM,
  input  logic [4:0]       WriteReg_MEM,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             UsesRt_ID,
  input  logic             Branch_ID,
  input  logic             BranchTaken_ID,
  input  logic             Jump_ID,
  input  logic             dmem_busy,
  input  logic             cnt_clr,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             PipeHold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN,
    MEMWAIT
  } state_t;

  localparam logic [WAIT_W-1:0] WMAX = WAIT_MAX[WAIT_W-1:0];
  localparam logic [WAIT_W-1:0] WONE = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CMAX = '1;
  localparam logic [CNT_W-1:0]  CONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;

  logic ldu;
  logic brd;
  logic stall;
  logic ctl;
  logic stall_inc;
  logic flush_inc;

  // $0 is hardwired zero, so it can never carry a dependency
  function automatic logic dep(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       urt
  );
    return (r != 5'd0) && ((r == rs) || (urt && (r == rt)));
  endfunction

  always_comb begin
    ldu = MemRead_EX && dep(Rt_EX, Rs_ID, Rt_ID, UsesRt_ID);
    brd = Branch_ID &&
          ((RegWrite_EX && dep(WriteReg_EX, Rs_ID, Rt_ID, UsesRt_ID)) ||
           (MemRead_MEM && dep(WriteReg_MEM, Rs_ID, Rt_ID, UsesRt_ID)));
    stall = ldu || brd;
    ctl   = Jump_ID || (Branch_ID && BranchTaken_ID);
  end

  // Freeze wins over stall, stall over control flush
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    PipeHold  = 1'b0;
    if (!reset_n) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (dmem_busy) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      PipeHold  = 1'b1;
    end else if (stall) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
    end else if (ctl) begin
      IFIDFlush = 1'b1;
    end
  end

  assign stall_inc = stall && !dmem_busy;
  assign flush_inc = ctl && !stall && !dmem_busy;

  always_comb begin
    wait_nxt = WONE;
    if (state == MEMWAIT) begin
      wait_nxt = (wait_cnt >= WMAX) ? WMAX : wait_cnt + WONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (dmem_busy) begin
        state    <= MEMWAIT;
        wait_cnt <= wait_nxt;
        if (wait_nxt == WMAX) mem_timeout <= 1'b1;
      end else begin
        state    <= RUN;
        wait_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != CMAX)) stall_cnt <= stall_cnt + CONE;
      if (flush_inc && (flush_cnt != CMAX)) flush_cnt <= flush_cnt + CONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed cases plus random
// stimulus against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W    = 2;
  localparam int WAIT_MAX = 4;
  localparam int WAIT_W   = 8;
  localparam int CSAT     = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             MemRead_EX;
  logic [4:0]       Rt_EX;
  logic             RegWrite_EX;
  logic [4:0]       WriteReg_EX;
  logic             MemRead_MEM;
  logic [4:0]       WriteReg_MEM;
  logic [4:0]       Rs_ID;
  logic [4:0]       Rt_ID;
  logic             UsesRt_ID;
  logic             Branch_ID;
  logic             BranchTaken_ID;
  logic             Jump_ID;
  logic             dmem_busy;
  logic             cnt_clr;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             PipeHold;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  int m_run;
  int m_stall;
  int m_flush;
  bit m_to;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(
    .CNT_W(CNT_W),
    .WAIT_MAX(WAIT_MAX),
    .WAIT_W(WAIT_W)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .MemRead_EX(MemRead_EX),
    .Rt_EX(Rt_EX),
    .RegWrite_EX(RegWrite_EX),
    .WriteReg_EX(WriteReg_EX),
    .MemRead_MEM(MemRead_MEM),
    .WriteReg_MEM(WriteReg_MEM),
    .Rs_ID(Rs_ID),
    .Rt_ID(Rt_ID),
    .UsesRt_ID(UsesRt_ID),
    .Branch_ID(Branch_ID),
    .BranchTaken_ID(BranchTaken_ID),
    .Jump_ID(Jump_ID),
    .dmem_busy(dmem_busy),
    .cnt_clr(cnt_clr),
    .PCWrite(PCWrite),
    .IFIDWrite(IFIDWrite),
    .IFIDFlush(IFIDFlush),
    .IDEXFlush(IDEXFlush),
    .PipeHold(PipeHold),
    .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [4:0] r);
    return (r != 0) && (r == Rs_ID || (UsesRt_ID && r == Rt_ID));
  endfunction

  task automatic idle();
    MemRead_EX     = 0;
    Rt_EX          = 0;
    RegWrite_EX    = 0;
    WriteReg_EX    = 0;
    MemRead_MEM    = 0;
    WriteReg_MEM   = 0;
    Rs_ID          = 0;
    Rt_ID          = 0;
    UsesRt_ID      = 0;
    Branch_ID      = 0;
    BranchTaken_ID = 0;
    Jump_ID        = 0;
    dmem_busy      = 0;
    cnt_clr        = 0;
  endtask

  task automatic rand_in();
    MemRead_EX     = ($urandom_range(0, 2) == 0);
    Rt_EX          = 5'($urandom_range(0, 3));
    RegWrite_EX    = $urandom_range(0, 1) == 1;
    WriteReg_EX    = 5'($urandom_range(0, 3));
    MemRead_MEM    = ($urandom_range(0, 2) == 0);
    WriteReg_MEM   = 5'($urandom_range(0, 3));
    Rs_ID          = 5'($urandom_range(0, 3));
    Rt_ID          = 5'($urandom_range(0, 3));
    UsesRt_ID      = $urandom_range(0, 1) == 1;
    Branch_ID      = ($urandom_range(0, 2) == 0);
    BranchTaken_ID = $urandom_range(0, 1) == 1;
    Jump_ID        = ($urandom_range(0, 5) == 0);
    dmem_busy      = ($urandom_range(0, 4) == 0);
    cnt_clr        = ($urandom_range(0, 19) == 0);
  endtask

  // One clock: check Mealy outputs mid-cycle, advance model, check state
  task automatic cyc();
    bit         st;
    bit         ct;
    logic [4:0] e;
    @(negedge clock);
    st = (MemRead_EX && reads(Rt_EX)) ||
         (Branch_ID && ((RegWrite_EX && reads(WriteReg_EX)) ||
                        (MemRead_MEM && reads(WriteReg_MEM))));
    ct = Jump_ID || (Branch_ID && BranchTaken_ID);
    if (dmem_busy) e = 5'b00001;
    else if (st)   e = 5'b00010;
    else if (ct)   e = 5'b11100;
    else           e = 5'b11000;
    check("outs", {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, PipeHold}, 32'(e));
    if (dmem_busy) begin
      m_run++;
      if (m_run >= WAIT_MAX) m_to = 1;
    end else begin
      m_run = 0;
    end
    if (cnt_clr) begin
      m_stall = 0;
      m_flush = 0;
    end else if (!dmem_busy) begin
      if (st && m_stall < CSAT) m_stall++;
      if (!st && ct && m_flush < CSAT) m_flush++;
    end
    @(posedge clock);
    #1;
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    check("mem_timeout", 32'(mem_timeout), 32'(m_to));
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n = 0;
    #1;
    check("rst_outs", {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, PipeHold}, 32'b00110);
    check("rst_timeout", 32'(mem_timeout), 0);
    check("rst_stall", 32'(stall_cnt), 0);
    check("rst_flush", 32'(flush_cnt), 0);
    m_run   = 0;
    m_stall = 0;
    m_flush = 0;
    m_to    = 0;
    idle();
    @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0;
    idle();
    m_run   = 0;
    m_stall = 0;
    m_flush = 0;
    m_to    = 0;
    #2;
    check("por_outs", {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, PipeHold}, 32'b00110);
    check("por_stall", 32'(stall_cnt), 0);
    do_reset();

    // Load-use on rs
    MemRead_EX = 1; Rt_EX = 5; Rs_ID = 5;
    cyc();
    check("ldu_stall", 32'(stall_cnt), 1);
    Rt_EX = 0; Rs_ID = 0;
    cyc();
    check("ldu_r0", 32'(stall_cnt), 1);

    // Load then beq on rt: two bubbles, taken branch ignored
    idle(); cnt_clr = 1;
    cyc();
    idle();
    MemRead_EX = 1; Rt_EX = 7; Rs_ID = 3; Rt_ID = 7; UsesRt_ID = 1;
    Branch_ID = 1; BranchTaken_ID = 1;
    cyc();
    MemRead_EX = 0; MemRead_MEM = 1; WriteReg_MEM = 7;
    cyc();
    check("ldbr_stall", 32'(stall_cnt), 2);
    check("ldbr_flush", 32'(flush_cnt), 0);

    // Taken branch, then jump
    idle(); Branch_ID = 1; BranchTaken_ID = 1;
    cyc();
    idle(); Jump_ID = 1;
    cyc();
    check("ctl_flush", 32'(flush_cnt), 2);

    // Freeze over an ldu, then one bubble
    idle(); MemRead_EX = 1; Rt_EX = 9; Rs_ID = 9; dmem_busy = 1;
    repeat (3) cyc();
    check("frz_stall", 32'(stall_cnt), 2);
    dmem_busy = 0;
    cyc();
    check("frz_bubble", 32'(stall_cnt), 3);

    // Watchdog: busy 6 cycles, sticky, cleared by async reset
    idle(); dmem_busy = 1;
    repeat (3) cyc();
    check("wd_early", 32'(mem_timeout), 0);
    cyc();
    check("wd_hit", 32'(mem_timeout), 1);
    repeat (2) cyc();
    dmem_busy = 0;
    cyc();
    check("wd_sticky", 32'(mem_timeout), 1);
    do_reset();

    // Reset mid-wait returns to RUN: a fresh 3-cycle wait must not time out
    dmem_busy = 1;
    repeat (2) cyc();
    do_reset();
    dmem_busy = 1;
    repeat (3) cyc();
    dmem_busy = 0;
    cyc();
    check("wd_restart", 32'(mem_timeout), 0);

    // Saturation and clear-with-stall
    idle(); MemRead_EX = 1; Rt_EX = 4; Rs_ID = 4;
    repeat (5) cyc();
    check("sat", 32'(stall_cnt), 3);
    cnt_clr = 1;
    cyc();
    check("clr", 32'(stall_cnt), 0);

    for (int s = 0; s < 4; s++) begin
      do_reset();
      repeat (250) begin
        rand_in();
        cyc();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
